// File: rtl/dtree_sequencer.sv
// Feeds one latched feature vector into dtree one sample per cycle, replaying it per tree level
// until dtree reports a result. Optional pass-limit timeout: define DTREE_SEQ_TIMEOUT_EN.
module dtree_sequencer #(
   parameter int FEATURES    = 3,
   parameter int IN_WIDTH    = 10,
   parameter int LEVEL_WIDTH = 2,
   parameter int PATH_WIDTH  = 2,
   parameter int MAX_PASSES  = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [FEATURES*IN_WIDTH-1:0] in_features,
   input  logic                         dt_ready,
   output logic                         dt_valid,
   output logic [IN_WIDTH-1:0]          dt_sample,
   input  logic [LEVEL_WIDTH-1:0]       dt_level,
   input  logic [PATH_WIDTH-1:0]        dt_path,
   input  logic                         dt_out_valid,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic [LEVEL_WIDTH-1:0]       res_level,
   output logic [PATH_WIDTH-1:0]        res_path,
   output logic                         res_error,
   output logic                         busy
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] STREAM = 2'd1;
   localparam logic [1:0] GAP    = 2'd2;
   localparam logic [1:0] RESULT = 2'd3;

   localparam int IDX_W = $clog2(FEATURES + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FEATURES);

   logic [1:0]                   state;
   logic [IDX_W-1:0]             idx;
   logic [FEATURES*IN_WIDTH-1:0] features;
   logic [IN_WIDTH-1:0]          cur_feature;
   logic                         timeout_hit;

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   always_comb begin
      cur_feature = '0;
      for (int k = 0; k < FEATURES; k++) begin
         if (idx == IDX_W'(k)) cur_feature = features[k*IN_WIDTH +: IN_WIDTH];
      end
   end

`ifdef DTREE_SEQ_TIMEOUT_EN
   localparam int PASS_W = $clog2(MAX_PASSES + 1);
   localparam logic [PASS_W-1:0] PASS_LIMIT = PASS_W'(MAX_PASSES - 1);
   localparam logic [PASS_W-1:0] PASS_SAT   = PASS_W'(MAX_PASSES);

   logic [PASS_W-1:0] passes;
   logic              wrap;
   logic              capture;

   assign wrap        = (state == STREAM) && !dt_out_valid && dt_ready && (idx == LAST_IDX);
   assign capture     = dt_out_valid && ((state == STREAM) || (state == GAP));
   assign timeout_hit = (passes == PASS_LIMIT);

   // Completed full passes of the current vector; saturates so it can never wrap back to 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         passes <= '0;
      end else if (state == IDLE) begin
         passes <= '0;
      end else if (wrap && (passes != PASS_SAT)) begin
         passes <= passes + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         res_error <= 1'b0;
      end else if (wrap && timeout_hit) begin
         res_error <= 1'b1;
      end else if (capture) begin
         res_error <= 1'b0;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign res_error   = 1'b0;
`endif

   // dt_out_valid wins over streaming so samples stop the cycle after dtree decides.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         idx       <= '0;
         features  <= '0;
         dt_valid  <= 1'b0;
         dt_sample <= '0;
         res_valid <= 1'b0;
         res_level <= '0;
         res_path  <= '0;
      end else begin
         case (state)
            IDLE: begin
               dt_valid <= 1'b0;
               if (in_valid) begin
                  features <= in_features;
                  idx      <= '0;
                  state    <= STREAM;
               end
            end
            STREAM: begin
               if (dt_out_valid) begin
                  dt_valid  <= 1'b0;
                  res_valid <= 1'b1;
                  res_level <= dt_level;
                  res_path  <= dt_path;
                  state     <= RESULT;
               end else if (!dt_ready) begin
                  dt_valid <= 1'b0;
               end else if (idx != LAST_IDX) begin
                  dt_valid  <= 1'b1;
                  dt_sample <= cur_feature;
                  idx       <= idx + 1'b1;
               end else begin
                  dt_valid <= 1'b0;
                  idx      <= '0;
                  if (timeout_hit) begin
                     res_valid <= 1'b1;
                     res_level <= '1;
                     res_path  <= '0;
                     state     <= RESULT;
                  end else begin
                     state <= GAP;
                  end
               end
            end
            GAP: begin
               dt_valid <= 1'b0;
               if (dt_out_valid) begin
                  res_valid <= 1'b1;
                  res_level <= dt_level;
                  res_path  <= dt_path;
                  state     <= RESULT;
               end else begin
                  state <= STREAM;
               end
            end
            RESULT: begin
               dt_valid <= 1'b0;
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dtree_sequencer.sv
// Scoreboard bench for dtree_sequencer: a behavioural dtree stand-in drives the sample side,
// expected samples/results are queued per vector and popped by an independent monitor.
module tb_dtree_sequencer;

   localparam int FEATURES   = 3;
   localparam int IN_WIDTH   = 10;
   localparam int MAX_PASSES = 8;

   typedef struct packed {
      logic [1:0] level;
      logic [1:0] path;
      logic       error;
   } result_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [29:0] in_features;
   logic        dt_ready;
   logic        dt_valid;
   logic [9:0]  dt_sample;
   logic [1:0]  dt_level;
   logic [1:0]  dt_path;
   logic        dt_out_valid;
   logic        res_valid;
   logic        res_ready;
   logic [1:0]  res_level;
   logic [1:0]  res_path;
   logic        res_error;
   logic        busy;

   logic [9:0] exp_samples[$];
   result_t    exp_results[$];

   int         total = 0;
   int         bad = 0;
   int         target;
   int         ready_mode;
   logic [1:0] cfg_level;
   logic [1:0] cfg_path;
   bit         done;

   always #5 clk = ~clk;

   dtree_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_features  (in_features),
      .dt_ready     (dt_ready),
      .dt_valid     (dt_valid),
      .dt_sample    (dt_sample),
      .dt_level     (dt_level),
      .dt_path      (dt_path),
      .dt_out_valid (dt_out_valid),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_level    (res_level),
      .res_path     (res_path),
      .res_error    (res_error),
      .busy         (busy)
   );

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h required=%0h", name, got, exp);
      end
   endtask

   // One vector: dtree answers after k samples (k=0 never); mode 0 random ready, 1 ready held, 2 stall.
   task automatic applyStimulus(input logic [9:0] f0, input logic [9:0] f1, input logic [9:0] f2,
                                input int k, input int mode, input logic [1:0] lv, input logic [1:0] pt,
                                input int hold, input bit preload, input logic [29:0] nxt);
      logic [9:0] vec [3];
      int         n;
      int         guard;
      result_t    r;
      vec[0] = f0;
      vec[1] = f1;
      vec[2] = f2;
      n = k;
      r = '{level: lv, path: pt, error: 1'b0};
`ifdef DTREE_SEQ_TIMEOUT_EN
      if (k == 0 || k > FEATURES * MAX_PASSES) begin
         n = FEATURES * MAX_PASSES;
         r = '{level: 2'b11, path: 2'b00, error: 1'b1};
      end
`endif
      for (int i = 0; i < n; i++) exp_samples.push_back(vec[i % FEATURES]);
      exp_results.push_back(r);
      target      = k;
      ready_mode  = mode;
      cfg_level   = lv;
      cfg_path    = pt;
      in_features = {f2, f1, f0};
      in_valid    = 1'b1;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (!in_ready) begin
         $display("[TB] FAIL accept_wait in_ready=%0b required=1", in_ready);
         $fatal(1, "[TB] stuck waiting for in_ready");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      guard = 0;
      while (!res_valid && guard < 2000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (!res_valid) begin
         $display("[TB] FAIL result_wait res_valid=%0b required=1", res_valid);
         $fatal(1, "[TB] stuck waiting for res_valid");
      end
      if (preload) begin
         in_features = nxt;
         in_valid    = 1'b1;
      end
      repeat (hold) begin
         @(posedge clk);
         #1;
      end
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
   endtask

   // Reset lands between clock edges after the first sample of a vector has gone out.
   task automatic resetMidStream();
      exp_samples.push_back(10'd11);
      target      = 0;
      ready_mode  = 1;
      in_features = {10'd33, 10'd22, 10'd11};
      in_valid    = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #10;
      reset = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin : stimulus
      int         k;
      int         mode;
      logic [9:0] a, b, c;
      reset       = 1'b1;
      in_valid    = 1'b0;
      in_features = '0;
      res_ready   = 1'b0;
      target      = 0;
      ready_mode  = 0;
      cfg_level   = 2'd0;
      cfg_path    = 2'd0;
      done        = 1'b0;
      #1 reset = 1'b0;
      #21 reset = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(10'd100, 10'd200, 10'd300, 6, 1, 2'd2, 2'b10, 2, 1'b0, '0);
      applyStimulus(10'd100, 10'd200, 10'd300, 6, 2, 2'd3, 2'b01, 0, 1'b0, '0);
      applyStimulus(10'd400, 10'd500, 10'd600, 1, 0, 2'd1, 2'b01, 1, 1'b0, '0);
      applyStimulus(10'd1, 10'd2, 10'd3, 3, 0, 2'd0, 2'b11, 5, 1'b1, {10'd7, 10'd6, 10'd5});
      applyStimulus(10'd5, 10'd6, 10'd7, 3, 0, 2'd2, 2'b00, 0, 1'b0, '0);
      resetMidStream();
`ifdef DTREE_SEQ_TIMEOUT_EN
      applyStimulus(10'd40, 10'd50, 10'd60, 0, 0, 2'd1, 2'b01, 1, 1'b0, '0);
`else
      applyStimulus(10'd40, 10'd50, 10'd60, 30, 0, 2'd1, 2'b01, 1, 1'b0, '0);
`endif
      for (int t = 0; t < 12; t++) begin
         k = int'($urandom_range(1, 14));
         mode = ((k % 3 == 0) && ($urandom_range(0, 1) == 1)) ? 1 : 0;
         a = 10'($urandom);
         b = 10'($urandom);
         c = 10'($urandom);
         applyStimulus(a, b, c, k, mode, 2'($urandom), 2'($urandom), int'($urandom_range(0, 3)), 1'b0, '0);
      end
      repeat (5) @(posedge clk);
      done = 1'b1;
   end

   // Behavioural dtree: counts accepted samples and raises out_valid once it has seen enough.
   initial begin : dtree_model
      int count;
      int stall;
      bit pending;
      dt_ready     = 1'b1;
      dt_out_valid = 1'b0;
      dt_level     = 2'd0;
      dt_path      = 2'd0;
      count        = 0;
      stall        = 0;
      pending      = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         dt_level = cfg_level;
         dt_path  = cfg_path;
         if (!reset || res_valid) begin
            count        = 0;
            stall        = 0;
            pending      = 1'b0;
            dt_out_valid = 1'b0;
         end else begin
            if (dt_valid) count++;
            if (pending) begin
               dt_out_valid = 1'b1;
               pending      = 1'b0;
            end else if (dt_valid && target != 0 && count == target) begin
               if (ready_mode == 1) pending = 1'b1;
               else dt_out_valid = 1'b1;
            end
            if (ready_mode == 2 && dt_valid && count == 2) stall = 3;
         end
         case (ready_mode)
            1: dt_ready = 1'b1;
            2: begin
               dt_ready = (stall == 0);
               if (stall > 0) stall--;
            end
            default: dt_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor: pops the scoreboard whenever the DUT shows a sample or a result.
   initial begin : monitor
      logic    last_ready;
      result_t got;
      #3;
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_dt_valid", 32'(dt_valid), 32'd0);
      checkOutput("rst_dt_sample", 32'(dt_sample), 32'd0);
      checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
      checkOutput("rst_res_level", 32'(res_level), 32'd0);
      checkOutput("rst_res_path", 32'(res_path), 32'd0);
      checkOutput("rst_res_error", 32'(res_error), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      wait (reset == 1'b1);
      last_ready = 1'b1;
      forever begin
         @(negedge clk or negedge reset);
         if (!reset) begin
            #1;
            checkOutput("async_dt_valid", 32'(dt_valid), 32'd0);
            checkOutput("async_res_valid", 32'(res_valid), 32'd0);
            checkOutput("async_busy", 32'(busy), 32'd0);
            checkOutput("async_in_ready", 32'(in_ready), 32'd1);
            exp_samples.delete();
            exp_results.delete();
            @(posedge reset);
            #1;
            checkOutput("release_in_ready", 32'(in_ready), 32'd1);
            checkOutput("release_busy", 32'(busy), 32'd0);
            last_ready = 1'b1;
         end else begin
            if (done) begin
               checkOutput("leftover_samples", 32'(exp_samples.size()), 32'd0);
               checkOutput("leftover_results", 32'(exp_results.size()), 32'd0);
               $display("test done: total=%0d bad=%0d", total, bad);
               $finish;
            end
            if (!last_ready) checkOutput("stall_dt_valid", 32'(dt_valid), 32'd0);
            if (dt_valid) begin
               if (exp_samples.size() == 0) begin
                  total++;
                  bad++;
                  $display("[TB] FAIL unexpected_sample got=%0d required=no sample", dt_sample);
               end else begin
                  checkOutput("dt_sample", 32'(dt_sample), 32'(exp_samples.pop_front()));
               end
            end
            if (res_valid) begin
               checkOutput("in_ready_during_result", 32'(in_ready), 32'd0);
               if (exp_results.size() == 0) begin
                  total++;
                  bad++;
                  $display("[TB] FAIL unexpected_result got=%0h required=no result",
                           {res_level, res_path, res_error});
               end else begin
                  got = '{level: res_level, path: res_path, error: res_error};
                  checkOutput("result", 32'(got), 32'(exp_results[0]));
                  if (res_ready) begin
                     void'(exp_results.pop_front());
                     checkOutput("samples_before_result", 32'(exp_samples.size()), 32'd0);
                  end
               end
            end
            last_ready = dt_ready;
         end
      end
   end

endmodule

// File: doc/dtree_sequencer.md
Name: dtree_sequencer

Overview:
- Hardware replacement for the bench-side feature feeder in front of `dtree`.
- Accepts one full feature vector per spike from the upstream feature extractor and serialises it into `dtree`'s one-sample-per-cycle ready/valid input.
- Replays the vector on every tree level until `dtree` asserts `out_valid`, then captures `level`/`path` and holds them on a result handshake.
- Sits between the feature extractor and the classifier result sink.

Parameters:
- FEATURES, 3, number of features per vector; samples streamed per pass.
- IN_WIDTH, 10, bits per feature sample.
- LEVEL_WIDTH, 2, width of `dtree` `level`.
- PATH_WIDTH, 2, width of `dtree` `path`.
- MAX_PASSES, 8, pass limit before timeout (only with DTREE_SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream feature vector valid.
- in_ready  out  1  sequencer can accept a vector.
- in_features  in  FEATURES*IN_WIDTH  feature vector; feature k occupies bits [k*IN_WIDTH +: IN_WIDTH].
- dt_ready  in  1  `dtree` ready.
- dt_valid  out  1  to `dtree` in_valid.
- dt_sample  out  IN_WIDTH  to `dtree` sample.
- dt_level  in  LEVEL_WIDTH  from `dtree` level.
- dt_path  in  PATH_WIDTH  from `dtree` path.
- dt_out_valid  in  1  `dtree` classification valid.
- res_valid  out  1  result held.
- res_ready  in  1  sink accepts result.
- res_level  out  LEVEL_WIDTH  captured level.
- res_path  out  PATH_WIDTH  captured path.
- res_error  out  1  result is a timeout; 0 when the feature is compiled out.
- busy  out  1  high in any state but IDLE.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; in_ready=1; dt_valid=0; dt_sample=0; res_valid=0; res_level=0; res_path=0; res_error=0; busy=0.
  - Internal: idx=0, pass count=0, feature register=0.
- All outputs are registered. in_ready = (state==IDLE).
- IDLE:
  - in_valid & in_ready at edge N: latch in_features, idx=0, passes=0, go STREAM.
- STREAM, per edge:
  - dt_out_valid=1 has priority over everything below: capture dt_level/dt_path into res_*, res_error=0, dt_valid=0, go RESULT. Remaining features are abandoned.
  - Else dt_ready=0: dt_valid=0, idx holds.
  - Else idx<FEATURES: dt_valid=1, dt_sample=feature[idx], idx+1.
  - Else (idx==FEATURES): dt_valid=0, idx=0, passes+1, go GAP.
- First sample latency: dt_valid rises at edge N+1 if dt_ready=1 at N+1.
- GAP (one cycle, dt_valid=0):
  - dt_out_valid=1: capture, go RESULT.
  - Else: go STREAM. The replay starts at feature 0 with the same latched vector.
- RESULT:
  - res_valid=1; res_* stable; dt_valid=0.
  - dt_out_valid is ignored.
  - res_ready=1 at edge: res_valid=0, go IDLE. in_ready rises the following cycle, so there is no same-cycle accept.
- dt_sample holds its last value whenever dt_valid=0.
- Reset mid-operation (any state): immediate return to reset values. The partial vector and any pending result are discarded.
- passes is a $clog2(MAX_PASSES+1)-bit saturating counter.

Optional Feature:
- Macro: DTREE_SEQ_TIMEOUT_EN.
- Defined:
  - In STREAM with idx==FEATURES and passes==MAX_PASSES-1, go RESULT instead of GAP.
  - Result: res_level=all ones, res_path=0, res_error=1.
  - Guards against a `dtree` that never asserts out_valid.
- Undefined:
  - No pass limit; passes logic is removed.
  - res_error tied 0.
  - The block waits indefinitely for dt_out_valid.

Test Plan:
1. Basic stream:
   - Stimulus: features {100,200,300}, dt_ready held 1, dt_out_valid pulsed with level=2, path=2'b10 after two passes.
   - Response: dt_sample sequence 100,200,300,(gap),100,200,300,(gap), then res_valid=1 with res_level=2, res_path=10, res_error=0.
2. Backpressure:
   - Stimulus: dt_ready=0 for 3 cycles after sample 200.
   - Response: dt_valid=0 during the stall; the next sample is 300, not 100; no duplicates.
3. Early result:
   - Stimulus: dt_out_valid=1 while idx=1 in STREAM (level=1, path=01).
   - Response: dt_valid=0 next cycle; RESULT with res_level=1, res_path=01; no further samples.
4. Result hold:
   - Stimulus: res_ready=0 for 5 cycles while in_valid=1 with a new vector {5,6,7}.
   - Response: res_* stable and in_ready=0 throughout. After res_ready=1, in_ready=1 one cycle later; the new vector streams as 5,6,7.
5. Async reset:
   - Stimulus: reset=0 asserted between clock edges mid-STREAM.
   - Response: dt_valid, res_valid and busy go 0 without waiting for clk. After release, in_ready=1 and the old vector is never replayed.
6. Timeout (DTREE_SEQ_TIMEOUT_EN, MAX_PASSES=8):
   - Stimulus: dt_out_valid never asserted.
   - Response: exactly 8 passes of 3 samples, then res_valid=1, res_error=1, res_level=2'b11, res_path=0.
   - Without the macro: streaming continues past 8 passes.
